// File: rtl/cv32e41s_mpu_ordq_if.sv
// rtl/cv32e41s_mpu_ordq_if.sv - core/bus handshake bundle for the MPU ordering queue
interface cv32e41s_mpu_ordq_if #(
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic                  core_trans_valid_i;
  logic                  core_trans_ready_o;
  logic                  core_trans_we_i;
  logic [ADDR_WIDTH-1:0] core_trans_addr_i;
  logic                  chk_err_i;
  logic                  chk_busy_i;
  logic                  bus_trans_valid_o;
  logic                  bus_trans_ready_i;
  logic [ADDR_WIDTH-1:0] bus_trans_addr_o;
  logic                  bus_trans_we_o;
  logic                  bus_resp_valid_i;
  logic                  core_resp_valid_o;
  logic [1:0]            core_resp_status_o;
  logic                  core_mpu_err_o;
  logic [CW-1:0]         outstanding_o;
  logic                  proto_err_o;

  modport slave (
    input  core_trans_valid_i, core_trans_we_i, core_trans_addr_i, chk_err_i, chk_busy_i,
           bus_trans_ready_i, bus_resp_valid_i,
    output core_trans_ready_o, bus_trans_valid_o, bus_trans_addr_o, bus_trans_we_o,
           core_resp_valid_o, core_resp_status_o, core_mpu_err_o, outstanding_o, proto_err_o
  );

  modport master (
    output core_trans_valid_i, core_trans_we_i, core_trans_addr_i, chk_err_i, chk_busy_i,
           bus_trans_ready_i, bus_resp_valid_i,
    input  core_trans_ready_o, bus_trans_valid_o, bus_trans_addr_o, bus_trans_we_o,
           core_resp_valid_o, core_resp_status_o, core_mpu_err_o, outstanding_o, proto_err_o
  );
endinterface

// File: rtl/cv32e41s_mpu_ordq.sv
// rtl/cv32e41s_mpu_ordq.sv - in-order MPU tag queue answering faulting and bus transfers in program order
module cv32e41s_mpu_ordq #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int STALL_ON_ERR    = 0,
  parameter int WRITE_EN        = 1
) (
  input logic                clk,
  input logic                rst_n,
  cv32e41s_mpu_ordq_if.slave ordq
);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0] MAX_COUNT = CW'(MAX_OUTSTANDING);

  logic [MAX_OUTSTANDING-1:0] q_err, q_we;
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [CW-1:0]              count;
  logic                       stall_q, proto_q;

  logic                  full, empty, avail, we_eff;
  logic                  push_err, push_ok, push;
  logic                  bus_valid, trans_ready;
  logic                  head_err, err_pop, bus_pop, pop, proto_set;
  logic [ADDR_WIDTH-1:0] addr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign we_eff = (WRITE_EN != 0) ? ordq.core_trans_we_i : 1'b0;
  assign full   = (count == MAX_COUNT);
  assign empty  = (count == '0);
  // Full blocks acceptance even when a pop lands in the same cycle, so ready never sees the response path.
  assign avail  = !full && !ordq.chk_busy_i && !stall_q;

  always_comb begin
    bus_valid   = 1'b0;
    trans_ready = 1'b0;
    push_err    = 1'b0;
    push_ok     = 1'b0;
    if (ordq.chk_err_i) begin
      trans_ready = avail;
      push_err    = ordq.core_trans_valid_i && avail;
    end else begin
      bus_valid   = ordq.core_trans_valid_i && avail;
      trans_ready = ordq.bus_trans_ready_i && avail;
      push_ok     = bus_valid && ordq.bus_trans_ready_i;
    end
  end

  assign push      = push_err || push_ok;
  assign head_err  = q_err[rd_ptr];
  assign err_pop   = !empty && head_err;
  assign bus_pop   = ordq.bus_resp_valid_i && !empty && !head_err;
  assign pop       = err_pop || bus_pop;
  assign proto_set = ordq.bus_resp_valid_i && (empty || head_err);
  assign addr      = ordq.core_trans_addr_i;

  assign ordq.core_trans_ready_o = trans_ready;
  assign ordq.bus_trans_valid_o  = bus_valid;
  assign ordq.bus_trans_addr_o   = addr;
  assign ordq.bus_trans_we_o     = we_eff;
  assign ordq.core_resp_valid_o  = pop;
  assign ordq.core_resp_status_o = err_pop ? (q_we[rd_ptr] ? 2'd2 : 2'd1) : 2'd0;
  assign ordq.core_mpu_err_o     = push_err;
  assign ordq.outstanding_o      = count;
  assign ordq.proto_err_o        = proto_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_err   <= '0;
      q_we    <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      stall_q <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      if (push) begin
        q_err[wr_ptr] <= push_err;
        q_we[wr_ptr]  <= we_eff;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end
      if (STALL_ON_ERR == 0) begin
        stall_q <= 1'b0;
      end else if (push_err) begin
        stall_q <= 1'b1;
      end else if (err_pop) begin
        stall_q <= 1'b0;
      end
      if (proto_set) begin
        proto_q <= 1'b1;
      end
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= MAX_COUNT);
  a_one_pop:     assert property (@(posedge clk) disable iff (!rst_n) ordq.core_resp_valid_o |-> (err_pop != bus_pop));
  a_one_push:    assert property (@(posedge clk) disable iff (!rst_n) !(push_err && push_ok));
endmodule

// File: tb/tb_cv32e41s_mpu_ordq.sv
// tb/tb_cv32e41s_mpu_ordq.sv - directed scoreboard bench for three MPU ordering queue configurations
module tb_cv32e41s_mpu_ordq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance 0: depth 2; instance 1: depth 2 with stall-on-error; instance 2: depth 3
  logic [2:0]  valid, we, err, busy, bready, bresp;
  logic [31:0] addr [3];
  logic [2:0]  tready, bvalid, bwe, rvalid, mpuerr, proto;
  logic [31:0] baddr [3];
  logic [1:0]  status [3];
  logic [1:0]  outst [3];
  logic [1:0]  sb [3][$];
  int n_chk = 0;
  int n_fail = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int MO = (g == 2) ? 3 : 2;
    cv32e41s_mpu_ordq_if #(.ADDR_WIDTH(32), .MAX_OUTSTANDING(MO)) ifc ();
    assign ifc.core_trans_valid_i = valid[g];
    assign ifc.core_trans_we_i    = we[g];
    assign ifc.core_trans_addr_i  = addr[g];
    assign ifc.chk_err_i          = err[g];
    assign ifc.chk_busy_i         = busy[g];
    assign ifc.bus_trans_ready_i  = bready[g];
    assign ifc.bus_resp_valid_i   = bresp[g];
    assign tready[g] = ifc.core_trans_ready_o;
    assign bvalid[g] = ifc.bus_trans_valid_o;
    assign baddr[g]  = ifc.bus_trans_addr_o;
    assign bwe[g]    = ifc.bus_trans_we_o;
    assign rvalid[g] = ifc.core_resp_valid_o;
    assign status[g] = ifc.core_resp_status_o;
    assign mpuerr[g] = ifc.core_mpu_err_o;
    assign outst[g]  = ifc.outstanding_o;
    assign proto[g]  = ifc.proto_err_o;
    cv32e41s_mpu_ordq #(
      .MAX_OUTSTANDING(MO),
      .ADDR_WIDTH(32),
      .STALL_ON_ERR((g == 1) ? 1 : 0),
      .WRITE_EN(1)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .ordq(ifc)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic ng();
    @(negedge clk);
  endtask

  task automatic req(input int d, input logic w, input logic e, input logic [31:0] a);
    valid[d] = 1'b1;
    we[d]    = w;
    err[d]   = e;
    addr[d]  = a;
  endtask

  task automatic idle(input int d);
    valid[d] = 1'b0;
    we[d]    = 1'b0;
    err[d]   = 1'b0;
  endtask

  task automatic chk_quiet(input int d, input string tag);
    chk($sformatf("%s_outst%0d", tag, d), 32'(outst[d]), 0);
    chk($sformatf("%s_ready%0d", tag, d), 32'(tready[d]), 0);
    chk($sformatf("%s_bvalid%0d", tag, d), 32'(bvalid[d]), 0);
    chk($sformatf("%s_rvalid%0d", tag, d), 32'(rvalid[d]), 0);
    chk($sformatf("%s_mpuerr%0d", tag, d), 32'(mpuerr[d]), 0);
    chk($sformatf("%s_proto%0d", tag, d), 32'(proto[d]), 0);
    chk($sformatf("%s_status%0d", tag, d), 32'(status[d]), 0);
  endtask

  // every core response is matched against the oldest expected status
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rvalid[d] === 1'b1) begin
        chk($sformatf("sb_nonempty%0d", d), 32'(sb[d].size() != 0), 1);
        if (sb[d].size() != 0) chk($sformatf("resp_status%0d", d), 32'(status[d]), 32'(sb[d].pop_front()));
      end
    end
  end

  initial begin
    logic ee [7];
    logic ew [7];
    ee = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ew = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    valid = '0; we = '0; err = '0; busy = '0; bready = '0; bresp = '0;
    for (int d = 0; d < 3; d++) addr[d] = '0;
    nx(); nx();
    ng();
    for (int d = 0; d < 3; d++) chk_quiet(d, "reset");
    nx();
    rst_n = 1'b1;
    bready = 3'b111;

    // back-to-back reads fill the depth-2 queue
    req(0, 1'b0, 1'b0, 32'h1000);
    ng(); chk("t1_bvalid", 32'(bvalid[0]), 1); chk("t1_addr", baddr[0], 32'h1000); chk("t1_ready_a", 32'(tready[0]), 1);
    sb[0].push_back(2'd0);
    nx(); addr[0] = 32'h1004;
    ng(); chk("t1_ready_b", 32'(tready[0]), 1);
    sb[0].push_back(2'd0);
    nx(); addr[0] = 32'h1008;
    ng(); chk("t1_full_ready", 32'(tready[0]), 0); chk("t1_outst2", 32'(outst[0]), 2); chk("t1_full_bvalid", 32'(bvalid[0]), 0);
    nx(); bresp[0] = 1'b1;
    ng(); chk("t1_resp", 32'(rvalid[0]), 1); chk("t1_ready_pop", 32'(tready[0]), 0);
    nx(); bresp[0] = 1'b0;
    ng(); chk("t1_outst1", 32'(outst[0]), 1); chk("t1_ready_c", 32'(tready[0]), 1);
    sb[0].push_back(2'd0);
    nx(); idle(0); bresp[0] = 1'b1;
    ng(); chk("t1_resp_b", 32'(rvalid[0]), 1);
    nx();
    ng(); chk("t1_resp_c", 32'(rvalid[0]), 1);
    nx(); bresp[0] = 1'b0;
    ng(); chk("t1_drain", 32'(outst[0]), 0);

    // error write queued behind an outstanding read
    nx(); req(0, 1'b0, 1'b0, 32'h2000);
    ng(); chk("t2_ready_a", 32'(tready[0]), 1);
    sb[0].push_back(2'd0);
    nx(); idle(0);
    nx(); req(0, 1'b1, 1'b1, 32'h2004);
    ng(); chk("t2_ready_b", 32'(tready[0]), 1); chk("t2_bvalid", 32'(bvalid[0]), 0);
    chk("t2_mpuerr", 32'(mpuerr[0]), 1); chk("t2_noresp3", 32'(rvalid[0]), 0);
    sb[0].push_back(2'd2);
    nx(); idle(0);
    ng(); chk("t2_noresp4", 32'(rvalid[0]), 0); chk("t2_outst", 32'(outst[0]), 2);
    nx();
    ng(); chk("t2_noresp5", 32'(rvalid[0]), 0);
    nx(); bresp[0] = 1'b1;
    ng(); chk("t2_resp6", 32'(rvalid[0]), 1);
    nx(); bresp[0] = 1'b0;
    ng(); chk("t2_resp7", 32'(rvalid[0]), 1); chk("t2_status7", 32'(status[0]), 2);
    nx();
    ng(); chk("t2_drain", 32'(outst[0]), 0); chk("t2_quiet", 32'(rvalid[0]), 0);

    // isolated faulting read
    nx(); req(0, 1'b0, 1'b1, 32'h3000);
    ng(); chk("t3_mpuerr", 32'(mpuerr[0]), 1); chk("t3_bvalid_t", 32'(bvalid[0]), 0); chk("t3_noresp", 32'(rvalid[0]), 0);
    sb[0].push_back(2'd1);
    nx(); idle(0);
    ng(); chk("t3_resp", 32'(rvalid[0]), 1); chk("t3_status", 32'(status[0]), 1);
    chk("t3_outst1", 32'(outst[0]), 1); chk("t3_bvalid_t1", 32'(bvalid[0]), 0);
    nx();
    ng(); chk("t3_outst0", 32'(outst[0]), 0); chk("t3_quiet", 32'(rvalid[0]), 0);

    // stall-on-error (inst 1) against non-stalling depth 3 (inst 2)
    nx(); req(1, 1'b0, 1'b0, 32'h4000); req(2, 1'b0, 1'b0, 32'h4000);
    ng(); chk("t4_ready1_a", 32'(tready[1]), 1); chk("t4_ready2_a", 32'(tready[2]), 1);
    sb[1].push_back(2'd0); sb[2].push_back(2'd0);
    nx(); req(1, 1'b0, 1'b1, 32'h4004); req(2, 1'b0, 1'b1, 32'h4004);
    ng(); chk("t4_mpuerr1", 32'(mpuerr[1]), 1); chk("t4_mpuerr2", 32'(mpuerr[2]), 1);
    sb[1].push_back(2'd1); sb[2].push_back(2'd1);
    nx(); req(1, 1'b0, 1'b0, 32'h4008); req(2, 1'b0, 1'b0, 32'h4008);
    ng(); chk("t4_stall1", 32'(tready[1]), 0); chk("t4_nostall2", 32'(tready[2]), 1);
    sb[2].push_back(2'd0);
    nx(); idle(2);
    ng(); chk("t4_stall1_c4", 32'(tready[1]), 0); chk("t4_bvalid1_c4", 32'(bvalid[1]), 0);
    nx(); bresp[1] = 1'b1; bresp[2] = 1'b1;
    ng(); chk("t4_resp1_c5", 32'(rvalid[1]), 1); chk("t4_resp2_c5", 32'(rvalid[2]), 1); chk("t4_stall1_c5", 32'(tready[1]), 0);
    nx(); bresp[1] = 1'b0; bresp[2] = 1'b0;
    ng(); chk("t4_errpop1", 32'(rvalid[1]), 1); chk("t4_stall1_c6", 32'(tready[1]), 0); chk("t4_errpop2", 32'(rvalid[2]), 1);
    nx(); bresp[2] = 1'b1;
    ng(); chk("t4_resume1", 32'(tready[1]), 1); chk("t4_resp2_c7", 32'(rvalid[2]), 1);
    sb[1].push_back(2'd0);
    nx(); idle(1); bresp[2] = 1'b0; bresp[1] = 1'b1;
    ng(); chk("t4_resp1_c8", 32'(rvalid[1]), 1);
    nx(); bresp[1] = 1'b0;
    ng(); chk("t4_drain1", 32'(outst[1]), 0); chk("t4_drain2", 32'(outst[2]), 0);

    // depth 3: overlapping accept/response pairs with mixed entries
    for (int k = 0; k < 8; k++) begin
      nx();
      idle(2);
      bresp[2] = 1'b0;
      if (k < 7) req(2, ew[k], ee[k], 32'h5000 + 32'(4 * k));
      if (k > 0 && !ee[k-1]) bresp[2] = 1'b1;
      ng();
      if (k < 7) begin
        chk($sformatf("t5_ready_%0d", k), 32'(tready[2]), 1);
        if (!ee[k]) chk($sformatf("t5_bwe_%0d", k), 32'(bwe[2]), 32'(ew[k]));
        sb[2].push_back(ee[k] ? (ew[k] ? 2'd2 : 2'd1) : 2'd0);
      end
      if (k > 0) chk($sformatf("t5_resp_%0d", k), 32'(rvalid[2]), 1);
    end
    nx(); idle(2); bresp[2] = 1'b0;
    ng(); chk("t5_drain", 32'(outst[2]), 0); chk("t5_proto", 32'(proto[2]), 0);

    // reset with two bus reads in flight, then a stray response
    nx(); req(0, 1'b0, 1'b0, 32'h6000);
    nx(); addr[0] = 32'h6004;
    nx(); idle(0); bready = '0; rst_n = 1'b0;
    ng(); chk_quiet(0, "t6_rst");
    nx(); rst_n = 1'b1; bready = 3'b111;
    nx(); bresp[0] = 1'b1;
    ng(); chk("t6_noresp", 32'(rvalid[0]), 0); chk("t6_proto_pre", 32'(proto[0]), 0);
    nx(); bresp[0] = 1'b0;
    ng(); chk("t6_proto", 32'(proto[0]), 1); chk("t6_outst", 32'(outst[0]), 0); chk("t6_quiet", 32'(rvalid[0]), 0);

    for (int d = 0; d < 3; d++) chk($sformatf("sb_empty%0d", d), 32'(sb[d].size()), 0);
    nx();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
